// File: rtl/rom_loader.sv
// ROM/OS image loader: queues data_io download bytes in a small FIFO and retires
// them to SDRAM in order, at most one write per memory slot.
module rom_loader #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [24:0] BASE0      = 25'h080000,
    parameter logic [24:0] BASE1      = 25'h068000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        mem_sync,
    output logic        loader_active,
    output logic        loader_we,
    output logic [24:0] loader_addr,
    output logic [7:0]  loader_data,
    output logic        overflow,
    output logic        done
);
    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t             state_q,    state_d;
    logic               dl_prev_q,  dl_prev_d;
    logic [IDX_W-1:0]   index_q,    index_d;
    logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic               active_q,   active_d;
    logic               we_q,       we_d;
    logic [ADDR_W-1:0]  addr_q,     addr_d;
    logic [DATA_W-1:0]  data_q,     data_d;
    logic               overflow_q, overflow_d;
    logic               done_q,     done_d;

    entry_t             fifo_mem [FIFO_DEPTH];
    entry_t             head;
    entry_t             push_entry;
    logic               dl_rise;
    logic               fifo_empty;
    logic               fifo_full;
    logic               wr_req;
    logic               push;
    logic               pop;

    // FIFO status and handshake decode
    assign dl_rise    = ioctl_download && !dl_prev_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign head       = fifo_mem[rd_ptr_q];
    assign pop        = mem_sync && !fifo_empty;
    assign wr_req     = (state_q == S_LOAD) && ioctl_wr;
    // a pop in the same cycle frees the slot a full-FIFO push needs
    assign push       = wr_req && (!fifo_full || pop);

    assign push_entry.addr = ioctl_addr + ((index_q == '0) ? BASE0 : BASE1);
    assign push_entry.data = ioctl_dout;

    always_comb begin
        state_d    = state_q;
        dl_prev_d  = ioctl_download;
        index_d    = index_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (wr_req && !push) begin
            overflow_d = 1'b1;
        end

        // SDRAM request only changes at slot boundaries
        if (mem_sync) begin
            we_d = pop;
            if (pop) begin
                addr_d = head.addr;
                data_d = head.data;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (dl_rise) begin
                    state_d    = S_LOAD;
                    index_d    = ioctl_index;
                    overflow_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (!ioctl_download) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mem_sync && fifo_empty) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        active_d = (state_d != S_IDLE);
        done_d   = (state_d == S_FINISH);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_IDLE;
            dl_prev_q  <= 1'b1;
            index_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            active_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dl_prev_q  <= dl_prev_d;
            index_q    <= index_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            active_q   <= active_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // Storage array; contents are don't-care while the count says empty
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end

    assign loader_active = active_q;
    assign loader_we     = we_q;
    assign loader_addr   = addr_q;
    assign loader_data   = data_q;
    assign overflow      = overflow_q;
    assign done          = done_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: directed scenarios plus randomized loads,
// compared every cycle against a queue-based reference model.
module tb_rom_loader;
    localparam int DEPTH = 8;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        mem_sync;
    logic        loader_active;
    logic        loader_we;
    logic [24:0] loader_addr;
    logic [7:0]  loader_data;
    logic        overflow;
    logic        done;

    always #5 clk_sys = ~clk_sys;

    rom_loader #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .mem_sync       (mem_sync),
        .loader_active  (loader_active),
        .loader_we      (loader_we),
        .loader_addr    (loader_addr),
        .loader_data    (loader_data),
        .overflow       (overflow),
        .done           (done)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int sync_per = 0;

    // reference model: a load is a phase, the FIFO is a plain queue
    int          m_phase;
    bit          m_prev;
    logic [7:0]  m_idx;
    logic [32:0] m_q[$];
    logic        m_active, m_we, m_ovf, m_done;
    logic [24:0] m_addr;
    logic [7:0]  m_data;
    logic [32:0] obs_w[$];

    function automatic logic [24:0] image_base(input logic [7:0] idx);
        return (idx == 8'd0) ? 25'h080000 : 25'h068000;
    endfunction

    function automatic void model_clock();
        bit          had;
        logic [32:0] e;
        logic [24:0] a;
        if (reset) begin
            m_phase = 0; m_q.delete(); m_prev = 1'b1; m_idx = '0;
            m_active = 0; m_we = 0; m_addr = '0; m_data = '0; m_ovf = 0; m_done = 0;
            return;
        end
        had = (m_q.size() != 0);
        if (mem_sync) begin
            if (had) begin
                e = m_q.pop_front();
                m_we = 1'b1; m_addr = e[32:8]; m_data = e[7:0];
            end else begin
                m_we = 1'b0;
            end
        end
        if (m_phase == 1 && ioctl_wr) begin
            if (m_q.size() < DEPTH) begin
                a = ioctl_addr + image_base(m_idx);
                m_q.push_back({a, ioctl_dout});
            end else begin
                m_ovf = 1'b1;
            end
        end
        case (m_phase)
            0: if (ioctl_download && !m_prev) begin m_phase = 1; m_idx = ioctl_index; m_ovf = 1'b0; end
            1: if (!ioctl_download) m_phase = 2;
            2: if (mem_sync && !had) m_phase = 3;
            default: m_phase = 0;
        endcase
        m_prev   = ioctl_download;
        m_active = (m_phase != 0);
        m_done   = (m_phase == 3);
    endfunction

    function automatic logic [36:0] obs_vec();
        return {loader_active, loader_we, loader_addr, loader_data, overflow, done};
    endfunction

    function automatic logic [36:0] exp_vec();
        return {m_active, m_we, m_addr, m_data, m_ovf, m_done};
    endfunction

    task automatic tick();
        if (sync_per > 0) mem_sync = ((cyc % sync_per) == 0);
        @(posedge clk_sys);
        #1;
        model_clock();
        if (mem_sync && loader_we && !reset) obs_w.push_back({loader_addr, loader_data});
        cyc++;
        ioctl_wr = 1'b0;
        mem_sync = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; mem_sync = 1'b0;
        tick(); tick();
        vectors++;
        if (obs_vec() !== 37'd0) begin
            errors++; $display("FAIL reset_zero: got %h want 0", obs_vec());
        end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'($urandom); ioctl_dout = 8'($urandom);
            mem_sync = (c[0] == 1'b1);
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL reset_idle cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single_byte();
        int ndone = 0;
        obs_w.delete(); sync_per = 4;
        for (int c = 0; c < 40; c++) begin
            ioctl_index = 8'h00;
            if (c == 0) ioctl_download = 1'b1;
            if (c == 2) begin ioctl_wr = 1'b1; ioctl_addr = 25'h00010; ioctl_dout = 8'hA5; end
            if (c == 4) ioctl_download = 1'b0;
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL single_byte cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (done) ndone++;
        end
        sync_per = 0;
        vectors++;
        if (ndone != 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", ndone); end
        vectors++;
        if (obs_w.size() != 1) begin
            errors++; $display("FAIL single_writes: got %0d want 1", obs_w.size());
        end else if (obs_w[0] !== {25'h080010, 8'hA5}) begin
            errors++; $display("FAIL single_entry: got %h want %h", obs_w[0], {25'h080010, 8'hA5});
        end
        vectors++;
        if (loader_active !== 1'b0) begin errors++; $display("FAIL single_active_end: got %b want 0", loader_active); end
    endtask

    task automatic test_addr_wrap();
        logic [7:0]  idx_t  [2] = '{8'h41, 8'h00};
        logic [24:0] off_t  [2] = '{25'h001FFFF, 25'h1FFFFFF};
        logic [24:0] want_t [2] = '{25'h087FFF, 25'h07FFFF};
        logic [7:0]  d;
        for (int k = 0; k < 2; k++) begin
            obs_w.delete(); sync_per = 4;
            d = 8'($urandom);
            for (int c = 0; c < 30; c++) begin
                ioctl_index = idx_t[k];
                ioctl_download = (c < 5);
                if (c == 2) begin ioctl_wr = 1'b1; ioctl_addr = off_t[k]; ioctl_dout = d; end
                tick();
                vectors++;
                if (obs_vec() !== exp_vec()) begin
                    errors++; $display("FAIL wrap%0d cyc %0d: got %h want %h", k, c, obs_vec(), exp_vec());
                end
            end
            sync_per = 0;
            vectors++;
            if (obs_w.size() != 1) begin
                errors++; $display("FAIL wrap%0d_writes: got %0d want 1", k, obs_w.size());
            end else if (obs_w[0] !== {want_t[k], d}) begin
                errors++; $display("FAIL wrap%0d_addr: got %h want %h", k, obs_w[0], {want_t[k], d});
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0]  dat [20];
        logic [7:0]  idx;
        logic [32:0] want;
        int ndone = 0;
        obs_w.delete(); sync_per = 0;
        idx = 8'($urandom_range(255, 1));
        for (int i = 0; i < 20; i++) dat[i] = 8'($urandom);
        for (int c = 0; c < 80; c++) begin
            ioctl_index = idx;
            ioctl_download = (c < 22);
            if (c >= 2 && c < 22) begin
                ioctl_wr = 1'b1; ioctl_addr = 25'h100 + 25'(c - 2); ioctl_dout = dat[c - 2];
            end
            if (c >= 24) mem_sync = ((c % 4) == 0);
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL overflow cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 23) begin
                vectors++;
                if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag: got %b want 1", overflow); end
            end
            if (done) ndone++;
        end
        vectors++;
        if (obs_w.size() != DEPTH) begin
            errors++; $display("FAIL overflow_writes: got %0d want %0d", obs_w.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                want = {25'h100 + 25'(i) + image_base(idx), dat[i]};
                vectors++;
                if (obs_w[i] !== want) begin
                    errors++; $display("FAIL overflow_order[%0d]: got %h want %h", i, obs_w[i], want);
                end
            end
        end
        vectors++;
        if (overflow !== 1'b1 || ndone != 1) begin
            errors++; $display("FAIL overflow_sticky: got ovf=%b done=%0d want ovf=1 done=1", overflow, ndone);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0]  dat [10];
        logic [32:0] want;
        obs_w.delete(); sync_per = 0;
        for (int i = 0; i < 10; i++) dat[i] = 8'($urandom);
        for (int c = 0; c < 70; c++) begin
            ioctl_index = 8'h05;
            ioctl_download = (c < 12);
            if (c >= 2 && c < 12) begin
                ioctl_wr = 1'b1; ioctl_addr = 25'h2000 + 25'(c - 2); ioctl_dout = dat[c - 2];
            end
            if (c == 10 || c >= 14) mem_sync = (c == 10) || ((c % 4) == 2);
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL full_pop cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 10) begin
                vectors++;
                if (overflow !== 1'b0) begin errors++; $display("FAIL full_pop_noovf: got %b want 0", overflow); end
            end
            if (c == 11) begin
                vectors++;
                if (overflow !== 1'b1) begin errors++; $display("FAIL full_pop_still_full: got %b want 1", overflow); end
            end
        end
        vectors++;
        if (obs_w.size() != 9) begin
            errors++; $display("FAIL full_pop_writes: got %0d want 9", obs_w.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                want = {25'h2000 + 25'(i) + 25'h068000, dat[i]};
                vectors++;
                if (obs_w[i] !== want) begin
                    errors++; $display("FAIL full_pop_order[%0d]: got %h want %h", i, obs_w[i], want);
                end
            end
        end
    endtask

    task automatic test_reset_midload();
        int ndone = 0;
        obs_w.delete(); sync_per = 0;
        for (int c = 0; c < 60; c++) begin
            ioctl_index = 8'h00;
            ioctl_download = !(c == 31 || c == 32 || c >= 38);
            reset = (c == 6 || c == 7);
            if ((c >= 2 && c < 5) || c == 35 || (c >= 8 && c < 30 && $urandom_range(1, 0) == 1)) begin
                ioctl_wr = 1'b1; ioctl_addr = 25'($urandom_range(4095, 0)); ioctl_dout = 8'($urandom);
            end
            if ((c >= 8 && c < 30 && $urandom_range(2, 0) == 0) || (c >= 40 && (c % 4) == 0)) mem_sync = 1'b1;
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL reset_mid cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c == 7) begin
                vectors++;
                if (obs_vec() !== 37'd0) begin errors++; $display("FAIL reset_mid_zero: got %h want 0", obs_vec()); end
            end
            if (c == 30) begin
                vectors++;
                if (obs_w.size() != 0 || loader_active !== 1'b0) begin
                    errors++; $display("FAIL reset_mid_quiet: got writes=%0d active=%b want 0/0", obs_w.size(), loader_active);
                end
            end
            if (done) ndone++;
        end
        reset = 1'b0;
        vectors++;
        if (obs_w.size() != 1 || ndone != 1) begin
            errors++; $display("FAIL reset_mid_fresh: got writes=%0d done=%0d want 1/1", obs_w.size(), ndone);
        end
    endtask

    task automatic test_drain();
        logic [32:0] e0, e1;
        logic [7:0]  d0, d1;
        obs_w.delete(); sync_per = 0;
        d0 = 8'($urandom); d1 = 8'($urandom);
        e0 = {25'h0300 + 25'h080000, d0};
        e1 = {25'h0301 + 25'h080000, d1};
        for (int c = 0; c < 22; c++) begin
            ioctl_index = 8'h00;
            ioctl_download = (c < 4);
            if (c == 2) begin ioctl_wr = 1'b1; ioctl_addr = 25'h0300; ioctl_dout = d0; end
            if (c == 3) begin ioctl_wr = 1'b1; ioctl_addr = 25'h0301; ioctl_dout = d1; end
            mem_sync = (c >= 8) && ((c % 4) == 0);
            tick();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL drain cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (c >= 1 && c <= 16 && loader_active !== 1'b1) begin
                vectors++; errors++; $display("FAIL drain_active cyc %0d: got 0 want 1", c);
            end
            if (c == 8 || c == 12) begin
                vectors++;
                if ({loader_we, loader_addr, loader_data} !== {1'b1, (c == 8) ? e0 : e1}) begin
                    errors++; $display("FAIL drain_slot cyc %0d: got %h want %h", c,
                        {loader_we, loader_addr, loader_data}, {1'b1, (c == 8) ? e0 : e1});
                end
            end
            if (c == 16) begin
                vectors++;
                if ({loader_we, done, loader_active} !== 3'b011) begin
                    errors++; $display("FAIL drain_finish: got we/done/act=%b want 011", {loader_we, done, loader_active});
                end
            end
            if (c == 17) begin
                vectors++;
                if ({done, loader_active} !== 2'b00) begin
                    errors++; $display("FAIL drain_idle: got done/act=%b want 00", {done, loader_active});
                end
            end
        end
    endtask

    task automatic test_random();
        int  len;
        int  tail;
        bit  fin;
        sync_per = 0;
        for (int ld = 0; ld < 8; ld++) begin
            len  = $urandom_range(40, 3);
            fin  = 0;
            tail = 0;
            ioctl_index = ($urandom_range(1, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
            for (int c = 0; c < 400 && tail < 3; c++) begin
                ioctl_download = (c < len);
                ioctl_wr   = ($urandom_range(1, 0) == 1);
                ioctl_addr = 25'($urandom);
                ioctl_dout = 8'($urandom);
                mem_sync   = ($urandom_range(3, 0) == 0);
                tick();
                vectors++;
                if (obs_vec() !== exp_vec()) begin
                    errors++; $display("FAIL random ld %0d cyc %0d: got %h want %h", ld, c, obs_vec(), exp_vec());
                end
                if (fin) tail++;
                if (done) fin = 1;
            end
            vectors++;
            if (!fin) begin errors++; $display("FAIL random_timeout ld %0d: got no done want done", ld); end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_addr_wrap();
        test_overflow();
        test_full_pop();
        test_reset_midload();
        test_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, buffered write entries; power of two, at least 2.
REQ-002 SHALL have parameter BASE0, default 25'h080000, SDRAM base for ioctl_index 0 (OS/ROM image).
REQ-003 SHALL have parameter BASE1, default 25'h068000, SDRAM base for any other ioctl_index.
REQ-004 SHALL have port clk_sys  in  1  system clock; one clock domain; reset is synchronous and active-high.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port ioctl_download  in  1  download in progress, from data_io.
REQ-007 SHALL have port ioctl_index  in  8  image index.
REQ-008 SHALL have port ioctl_wr  in  1  one-cycle byte-valid strobe.
REQ-009 SHALL have port ioctl_addr  in  25  byte offset within image.
REQ-010 SHALL have port ioctl_dout  in  8  byte data.
REQ-011 SHALL have port mem_sync  in  1  one-cycle strobe marking the start of each SDRAM slot.
REQ-012 SHALL have port loader_active  out  1  SDRAM mux owned by loader.
REQ-013 SHALL have port loader_we  out  1  SDRAM write request for the current slot.
REQ-014 SHALL have port loader_addr  out  25  SDRAM write address.
REQ-015 SHALL have port loader_data  out  8  SDRAM write data.
REQ-016 SHALL have port overflow  out  1  sticky: a byte was dropped.
REQ-017 SHALL have port done  out  1  one-cycle pulse when a load has fully retired.

Function
REQ-018 SHALL implement states IDLE, LOAD, DRAIN, FINISH.
REQ-019 IDLE -> LOAD on rising edge of ioctl_download (prev-level register); this edge latches ioctl_index, clears overflow, and asserts loader_active on the next cycle.
REQ-020 LOAD -> DRAIN when ioctl_download falls.
REQ-021 DRAIN -> FINISH at the first mem_sync where the FIFO is empty; the same mem_sync drives loader_we low.
REQ-022 FINISH -> IDLE after one cycle; done = 1 for that cycle; loader_active = 0 from the IDLE cycle on.
REQ-023 loader_active SHALL be 1 in LOAD, DRAIN and FINISH, else 0.
REQ-024 Push: in LOAD, an ioctl_wr cycle writes {ioctl_addr + base, ioctl_dout} to the FIFO; base = BASE0 if latched index == 0, else BASE1.
REQ-025 The add SHALL be 25-bit modulo 2^25 (wraps, no carry out).
REQ-026 ioctl_wr outside LOAD SHALL be ignored.
REQ-027 Pop: on mem_sync with the FIFO non-empty, the head entry loads into loader_addr/loader_data and loader_we = 1.
REQ-028 On mem_sync with the FIFO empty, loader_we = 0 and loader_addr/loader_data hold their values.
REQ-029 loader_we/addr/data SHALL only change on mem_sync cycles (held for a whole slot); at most one write per slot.
REQ-030 Full: ioctl_wr with the FIFO full and no simultaneous pop drops the byte and sets overflow (sticky until next load start or reset).
REQ-031 Full with simultaneous pop: the push SHALL succeed; no overflow.
REQ-032 Simultaneous push and pop on an empty FIFO: pop sees empty (no write); the pushed entry is stored.
REQ-033 Pointer and count widths SHALL be clog2(FIFO_DEPTH) and clog2(FIFO_DEPTH)+1; pointers wrap naturally.
REQ-034 Write order to SDRAM SHALL equal ioctl_wr order.

Reset
REQ-035 On reset: state IDLE, FIFO empty, loader_active = 0, loader_we = 0, loader_addr = 0, loader_data = 0, overflow = 0, done = 0.
REQ-036 On reset the download prev-level register SHALL be 1, so a download still high when reset releases is ignored until ioctl_download drops and rises again.
REQ-037 Reset mid-load SHALL discard all buffered bytes with no further writes and no done pulse.

Verification
REQ-038 Index 0, one byte at addr 0x00010 = 0xA5, mem_sync every 4 cycles -> one slot with loader_we = 1, addr 0x080010, data 0xA5; then done pulses and loader_active falls.
REQ-039 Index 0x41, addr 0x1FFFF -> loader_addr 0x087FFF; a 0x1FFFFFF offset wraps mod 2^25.
REQ-040 20 back-to-back ioctl_wr cycles with no mem_sync, depth 8 -> first 8 retained in order, overflow = 1, exactly 8 SDRAM writes after mem_sync resumes.
REQ-041 FIFO full with ioctl_wr and mem_sync in the same cycle -> no overflow; count unchanged; next write retires the oldest entry.
REQ-042 Reset asserted with 3 entries queued, download held high -> outputs zero, no writes, block stays IDLE until a fresh download rising edge.
REQ-043 Download falls with 2 entries queued -> DRAIN; 2 write slots, then 1 empty slot, then done; loader_active high throughout.
